// File: rtl/div_rest_seq.sv
// Sequential restoring divider: one quotient bit per clock, req/ack handshake.
// Optional two's-complement mode (sgn port) is enabled by defining DIV_SIGNED_EN.
module div_rest_seq #(
    parameter int unsigned WIDTH_A = 16,
    parameter int unsigned WIDTH_B = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic [WIDTH_A+WIDTH_B-1:0] data_req,
`ifdef DIV_SIGNED_EN
    input  logic                       sgn,
`endif
    output logic                       busy,
    output logic                       ack,
    output logic [WIDTH_A+WIDTH_B-1:0] data_ack,
    output logic                       dz
);

    localparam int unsigned WA = WIDTH_A;
    localparam int unsigned WB = WIDTH_B;
    localparam int unsigned CW = $clog2(WIDTH_A + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [WA-1:0]    aq, aq_nxt;
    logic [WB-1:0]    bm, bm_nxt;
    logic [WB:0]      p, p_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             busy_nxt, ack_nxt, dz_nxt;
    logic [WA+WB-1:0] data_ack_nxt;

    logic [WA-1:0]    a_in, a_mag, q_step, q_fin;
    logic [WB-1:0]    b_in, b_mag, r_fin;
    logic [WB+1:0]    sh, diff;
    logic [WB:0]      p_step;

    assign a_in = data_req[WA+WB-1:WB];
    assign b_in = data_req[WB-1:0];

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    assign sh     = {p, aq[WA-1]};
    assign diff   = sh - {2'b00, bm};
    assign p_step = diff[WB+1] ? sh[WB:0] : diff[WB:0];
    assign q_step = {aq[WA-2:0], ~diff[WB+1]};

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg;
    logic neg_q, neg_q_nxt, neg_r, neg_r_nxt;

    assign a_neg = sgn & a_in[WA-1];
    assign b_neg = sgn & b_in[WB-1];
    assign a_mag = a_neg ? -a_in : a_in;
    assign b_mag = b_neg ? -b_in : b_in;
    // Quotient takes the XOR of operand signs, remainder follows the dividend.
    assign q_fin = neg_q ? -q_step : q_step;
    assign r_fin = neg_r ? -p_step[WB-1:0] : p_step[WB-1:0];
`else
    assign a_mag = a_in;
    assign b_mag = b_in;
    assign q_fin = q_step;
    assign r_fin = p_step[WB-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            aq       <= '0;
            bm       <= '0;
            p        <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            ack      <= 1'b0;
            data_ack <= '0;
            dz       <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            aq       <= aq_nxt;
            bm       <= bm_nxt;
            p        <= p_nxt;
            cnt      <= cnt_nxt;
            busy     <= busy_nxt;
            ack      <= ack_nxt;
            data_ack <= data_ack_nxt;
            dz       <= dz_nxt;
`ifdef DIV_SIGNED_EN
            neg_q    <= neg_q_nxt;
            neg_r    <= neg_r_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        aq_nxt       = aq;
        bm_nxt       = bm;
        p_nxt        = p;
        cnt_nxt      = cnt;
        busy_nxt     = busy;
        ack_nxt      = 1'b0;
        data_ack_nxt = data_ack;
        dz_nxt       = dz;
`ifdef DIV_SIGNED_EN
        neg_q_nxt    = neg_q;
        neg_r_nxt    = neg_r;
`endif
        case (state)
            S_IDLE: begin
                if (req) begin
                    busy_nxt = 1'b1;
                    aq_nxt   = a_mag;
                    bm_nxt   = b_mag;
                    p_nxt    = '0;
                    cnt_nxt  = CW'(WIDTH_A);
`ifdef DIV_SIGNED_EN
                    neg_q_nxt = a_neg ^ b_neg;
                    neg_r_nxt = a_neg;
`endif
                    // Zero divisor skips CALC and reports straight from the raw operand.
                    if (b_in == '0) begin
                        state_nxt    = S_DONE;
                        ack_nxt      = 1'b1;
                        data_ack_nxt = {a_in[WB-1:0], {WA{1'b1}}};
                        dz_nxt       = 1'b1;
                    end else begin
                        state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                aq_nxt  = q_step;
                p_nxt   = p_step;
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt    = S_DONE;
                    ack_nxt      = 1'b1;
                    data_ack_nxt = {r_fin, q_fin};
                    dz_nxt       = 1'b0;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/div_rest_seq.md
# div_rest_seq

- Parametrised sequential restoring divider, one quotient bit per clock.
- Configurable dividend and divisor widths, divide-by-zero detection, and optional two's-complement signed mode.
- Generalises the fixed 2·WIDTH packed-operand divider, keeping the same req/ack handshake and the {remainder, quotient} result packing.
- Intended as the shared arithmetic divider for datapath blocks needing low-area division.

## Interface
- WIDTH_A, default 16: dividend and quotient width; minimum 2.
- WIDTH_B, default 8: divisor and remainder width; minimum 2, and WIDTH_B ≤ WIDTH_A.
- clk  input  1: clock; all logic on the rising edge.
- rst  input  1: reset, synchronous and active-high.
- req  input  1: start request; sampled only in IDLE.
- data_req  input  WIDTH_A+WIDTH_B: packed operands {A (dividend, upper), B (divisor, lower)}.
- sgn  input  1: signed operation; present only with DIV_SIGNED_EN.
- busy  output  1: high while an operation is in progress (CALC or DONE).
- ack  output  1: one-cycle pulse; result valid.
- data_ack  output  WIDTH_A+WIDTH_B: packed result {R (remainder, upper WIDTH_B bits), Q (quotient, lower WIDTH_A bits)}.
- dz  output  1: divide-by-zero flag, updated together with data_ack.

## Operation
**FSM states:** IDLE, CALC, DONE.

- **IDLE**
  - On req=1: latch A and B (and sgn), clear the partial remainder P (WIDTH_B+1 bits), load the bit counter with WIDTH_A.
  - If B≠0, go to CALC. If B=0, go to DONE.
  - On req=0: stay in IDLE.
- **CALC, each cycle**
  - Form {P,Aq} shifted left by 1.
  - Compute T = P − |B|.
  - If T ≥ 0: P = T and the new quotient LSB = 1. Otherwise restore P and the quotient LSB = 0.
  - Decrement the counter; when it reaches 0, go to DONE.
- **DONE**
  - Register data_ack and dz, pulse ack=1, then return to IDLE.
- **Divide by zero:** Q = all ones, R = A[WIDTH_B-1:0], dz=1. No CALC cycles.
- **Width rules:** unsigned R < B always fits WIDTH_B bits. P carries one guard bit so the subtract never loses a carry.
- **req outside IDLE:** ignored, not queued. A request must be held, or reissued, once busy=0.
- **Holding behaviour:**
  - data_ack and dz hold their value until the next operation reaches DONE.
  - data_req may change freely after acceptance.
- **Reset mid-operation:** abort; no ack; all outputs return to reset values the following cycle.

## Timing
- **Reset values:** ack=0, busy=0, data_ack=0, dz=0, state IDLE.
- **Reference point:** req accepted at the edge ending cycle 0.
- **busy:** high in cycles 1..WIDTH_A+1.
- **Normal latency:**
  - CALC occupies cycles 1..WIDTH_A.
  - DONE, with ack=1 and data_ack valid, is cycle WIDTH_A+1.
  - Latency is WIDTH_A+1 clocks.
- **Divide-by-zero latency:** DONE in cycle 1; latency 1.
- **Throughput:** IDLE lasts at least 1 cycle between operations. With req held high, the next operation is accepted in cycle WIDTH_A+2, giving one result per WIDTH_A+2 cycles.
- **Timing independence:** latency does not depend on operand values, except for B=0.

## Configuration
- **DIV_SIGNED_EN defined**
  - Port sgn exists.
  - With sgn=1, A and B are two's complement. CALC operates on magnitudes.
  - In DONE: Q is negated if sign(A)≠sign(B); R is negated if A<0.
  - Result: truncation toward zero, and R takes the sign of A.
  - Most-negative A divided by −1 gives Q = most negative (wrap) and R = 0.
  - Signed divide-by-zero uses the same Q/R/dz values as unsigned.
  - Latency is unchanged; the correction is absorbed into DONE.
- **DIV_SIGNED_EN undefined**
  - No sgn port; operation is unsigned only.
  - No negation logic is synthesised.

## Test plan
All cases use WIDTH_A=16 and WIDTH_B=8.
- **Basic unsigned:** A=1000, B=7 → ack in cycle 17, data_ack = {8'h06, 16'h008E}, dz=0. busy is high in cycles 1–17.
- **Divide by zero:** A=16'h1234, B=0 → ack in cycle 1, data_ack = {8'h34, 16'hFFFF}, dz=1.
- **Extremes:**
  - A=16'hFFFF, B=8'h01 → Q=16'hFFFF, R=0.
  - A=5, B=8'hFF → Q=0, R=5.
- **Signed (DIV_SIGNED_EN, sgn=1):**
  - A=−100 (16'hFF9C), B=7 → Q=16'hFFF2 (−14), R=8'hFE (−2).
  - A=16'h8000, B=8'hFF → Q=16'h8000, R=0.
- **Handshake:**
  - req pulsed in cycle 5 of a busy operation → ignored; exactly one ack.
  - req held high continuously → ack in cycles 17, 35, 53….
- **Reset mid-operation:** rst=1 in cycle 6 → no ack; cycle 7 outputs all 0. A new request for 1000/7 then completes correctly after 17 cycles.
